// File: rtl/reqack_fifo_responder.sv
// reqack_fifo_responder: buffered responder end of the req/ack pull handshake.
// Words arrive on a push-style valid/ready stream into a FIFO and are served
// to a downstream initiator as one-cycle ack pulses with registered data.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   din_valid  upstream word present on din
//   din_ready  FIFO can accept a word this cycle (combinational, level != depth)
//   din        upstream data
//   req        downstream request level
//   ack        registered one-cycle acknowledge; dout valid while high
//   dout       registered served data
//   hold       suppresses new acks while high
//   level      FIFO occupancy, 0..depth
//   count      acks issued since reset (wraps at 2**32)
module reqack_fifo_responder #(
  parameter int unsigned           data_width    = 32,
  parameter int unsigned           depth_log2    = 3,
  parameter logic [data_width-1:0] initial_value = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [data_width-1:0] din,
  input  logic                  req,
  output logic                  ack,
  output logic [data_width-1:0] dout,
  input  logic                  hold,
  output logic [depth_log2:0]   level,
  output logic [31:0]           count
);

  localparam int unsigned DEPTH = 2 ** depth_log2;
  localparam int unsigned PTR_W = depth_log2;
  localparam int unsigned LVL_W = depth_log2 + 1;
  localparam int unsigned CNT_W = 32;

  logic [data_width-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_ack;
  logic [data_width-1:0] r_dout;
  logic [CNT_W-1:0]      r_count;

  logic w_full;
  logic w_push;
  logic w_serve;

  // Full check is on occupancy only; a same-cycle pop does not open a slot.
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_push  = din_valid & ~w_full;
  // Gating on r_ack keeps ack from ever being high two cycles running.
  assign w_serve = req & ~r_ack & ~hold & (r_level != '0);

  // Storage array: not reset, contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ack    <= 1'b0;
      r_dout   <= initial_value;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_serve) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_dout   <= r_mem[r_rd_ptr];
        r_count  <= r_count + CNT_W'(1);
      end
      r_ack <= w_serve;
      case ({w_push, w_serve})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign din_ready = ~w_full;
  assign ack       = r_ack;
  assign dout      = r_dout;
  assign level     = r_level;
  assign count     = r_count;

endmodule

// File: tb/tb_reqack_fifo_responder.sv
// Self-checking bench for reqack_fifo_responder: directed scenarios plus a
// randomized phase, all checked against a queue-based reference model.
module tb_reqack_fifo_responder;

  localparam int unsigned DW    = 32;
  localparam int unsigned DL2   = 3;
  localparam int unsigned DEPTH = 8;
  localparam logic [DW-1:0] INIT = 32'hDEAD_BEEF;

  logic          clk;
  logic          rst;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] din;
  logic          req;
  logic          ack;
  logic [DW-1:0] dout;
  logic          hold;
  logic [DL2:0]  level;
  logic [31:0]   count;

  reqack_fifo_responder #(
    .data_width   (DW),
    .depth_log2   (DL2),
    .initial_value(INIT)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .din      (din),
    .req      (req),
    .ack      (ack),
    .dout     (dout),
    .hold     (hold),
    .level    (level),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ack;
  logic [DW-1:0] m_dout;
  logic [31:0]   m_count;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ack   = 1'b0;
    m_dout  = INIT;
    m_count = '0;
  endtask

  // One clock cycle: drive inputs, predict, clock, compare. Called at posedge+1.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic h, output logic acc);
    logic m_push;
    logic m_serve;
    din_valid = v;
    din       = d;
    req       = r;
    hold      = h;
    #1;
    chk("din_ready", 64'(din_ready), 64'(q.size() != DEPTH));
    m_push  = v && (q.size() < DEPTH);
    m_serve = r && !m_ack && !h && (q.size() > 0);
    @(posedge clk);
    #1;
    if (m_serve) begin
      m_dout = q.pop_front();
      m_count++;
    end
    m_ack = m_serve;
    if (m_push) q.push_back(d);
    acc = m_push;
    chk("ack",   64'(ack),   64'(m_ack));
    chk("dout",  64'(dout),  64'(m_dout));
    chk("level", 64'(level), 64'(q.size()));
    chk("count", 64'(count), 64'(m_count));
  endtask

  task automatic drain();
    logic dmy;
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0 && !m_ack) break;
      step(1'b0, '0, 1'b1, 1'b0, dmy);
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, dmy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic          dmy;
    logic          acc;
    logic [DW-1:0] order[$];
    int            pushed;
    int            served;

    rst = 1'b0; din_valid = 1'b0; din = '0; req = 1'b0; hold = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",   64'(ack),   64'd0);
    chk("rst_dout",  64'(dout),  64'(INIT));
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: push 1,2,3 with req held high
    step(1'b1, 32'd1, 1'b1, 1'b0, dmy);
    step(1'b1, 32'd2, 1'b1, 1'b0, dmy);
    chk("t1_first_ack", 64'(ack), 64'd1);
    chk("t1_first_dout", 64'(dout), 64'd1);
    step(1'b1, 32'd3, 1'b1, 1'b0, dmy);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, dmy);
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_dout_hold", 64'(dout), 64'd3);
    chk("t1_level", 64'(level), 64'd0);

    // 2: empty stall, then a single push
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, dmy);
      chk("t2_stall_ack", 64'(ack), 64'd0);
    end
    step(1'b1, 32'd42, 1'b1, 1'b0, dmy);
    chk("t2_no_bypass", 64'(ack), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0, dmy);
    chk("t2_ack", 64'(ack), 64'd1);
    chk("t2_dout", 64'(dout), 64'd42);
    drain();

    // 3: fill, overflow attempt, then stream 100 words across wraps
    for (int i = 0; i < 8; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, dmy);
      order.push_back(DW'(i));
    end
    chk("t3_full_level", 64'(level), 64'd8);
    chk("t3_full_ready", 64'(din_ready), 64'd0);
    step(1'b1, 32'd999, 1'b0, 1'b0, dmy);
    chk("t3_ovf_level", 64'(level), 64'd8);
    pushed = 0;
    served = 0;
    for (int i = 0; i < 600; i++) begin
      if (pushed >= 100 && q.size() == 0) break;
      if (pushed < 100) begin
        step(1'b1, DW'(1000 + pushed), 1'b1, 1'b0, acc);
        if (acc) begin
          order.push_back(DW'(1000 + pushed));
          pushed++;
        end
      end else begin
        step(1'b0, '0, 1'b1, 1'b0, dmy);
      end
      if (ack) begin
        chk("t3_order", 64'(dout), 64'(order[served]));
        served++;
      end
    end
    step(1'b0, '0, 1'b1, 1'b0, dmy);
    if (ack) begin
      chk("t3_order", 64'(dout), 64'(order[served]));
      served++;
    end
    chk("t3_served", 64'(served), 64'd108);
    drain();

    // 4: simultaneous push and serve at level 4
    for (int i = 0; i < 4; i++) step(1'b1, DW'(500 + i), 1'b0, 1'b0, dmy);
    step(1'b1, 32'd504, 1'b1, 1'b0, dmy);
    chk("t4_level", 64'(level), 64'd4);
    chk("t4_oldest", 64'(dout), 64'd500);
    drain();

    // 5: hold with 3 words buffered
    for (int i = 0; i < 3; i++) step(1'b1, DW'(700 + i), 1'b0, 1'b0, dmy);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, dmy);
      chk("t5_hold_ack", 64'(ack), 64'd0);
    end
    step(1'b0, '0, 1'b1, 1'b0, dmy);
    chk("t5_release_ack", 64'(ack), 64'd1);
    chk("t5_release_dout", 64'(dout), 64'd700);
    step(1'b0, '0, 1'b1, 1'b0, dmy);
    chk("t5_gap", 64'(ack), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0, dmy);
    chk("t5_second", 64'(dout), 64'd701);
    drain();

    // 6: asynchronous reset while ack is high and level is 5
    for (int i = 0; i < 6; i++) step(1'b1, DW'(800 + i), 1'b0, 1'b0, dmy);
    step(1'b0, '0, 1'b1, 1'b0, dmy);
    chk("t6_pre_ack", 64'(ack), 64'd1);
    chk("t6_pre_level", 64'(level), 64'd5);
    din_valid = 1'b0; req = 1'b0; hold = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("t6_async_ack",   64'(ack),   64'd0);
    chk("t6_async_level", 64'(level), 64'd0);
    chk("t6_async_count", 64'(count), 64'd0);
    chk("t6_async_dout",  64'(dout),  64'(INIT));
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'd77, 1'b0, 1'b0, dmy);
    step(1'b1, 32'd78, 1'b1, 1'b0, dmy);
    chk("t6_first_served", 64'(dout), 64'd77);
    drain();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) < 2), dmy);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
